multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Control unit for the SigmaCore multicycle datapath: a Moore FSM that sequences fetch, decode, execute, memory and write-back.
- Drives every datapath control input (pc_write, ir_write, reg_write, mem_*, mux selects, imm_src, alu_op_type, A/B/ALUOut enables).
- Consumes the latched instruction register and the ALU zero flag.
- Supports RV32I R-type, I-ALU, LW, SW, BEQ/BNE, JAL, JALR and AUIPC. Any other instruction sends the FSM to a sticky trap.

Parameters:
IMEM_WAIT_CYCLES, 0, extra FETCH cycles before ir_write is asserted (instruction memory read latency).
DMEM_WAIT_CYCLES, 0, extra MEM_READ cycles before advancing (data memory read latency).

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  synchronous, active-low reset
instruction_in  input  32  instruction register contents from the datapath
alu_zero_flag_in  input  1  ALU zero flag, combinational, same cycle
pc_write, ir_write, reg_write, mem_write, mem_read, reg_a_write, reg_b_write, alu_out_write  output  1 each  datapath enables
pc_source  output  2  00 ALU result, 01 ALUOut (branch/JAL), 10 ALUOut (JALR)
mem_to_reg  output  1  0 ALUOut, 1 MDR
alu_src_a  output  1  0 reg A, 1 PC
alu_src_b  output  2  00 reg B, 01 immediate, 10 constant 4
imm_src  output  3  000 I, 001 S, 010 B, 011 U, 100 J
alu_op_type  output  2  00 add, 01 subtract/compare, 10 R-type funct, 11 I-type funct
illegal_instr  output  1  sticky trap indicator
state_out  output  4  current state encoding, debug
instret_count  output  32  retired-instruction count (see Optional Feature)

Behaviour:
- Outputs are pure functions of state plus instruction_in/alu_zero_flag_in.
- Unlisted outputs are 0 in every state.
- While reset_n=0, all enables are forced to 0 combinationally. At the clock edge: state<=FETCH, wait counter<=0, illegal_instr<=0, instret_count<=0.
- FETCH:
  - Wait counter counts to IMEM_WAIT_CYCLES.
  - In the final FETCH cycle: ir_write=1, then go to DECODE.
  - The PC is not touched in FETCH.
- DECODE:
  - reg_a_write=1, reg_b_write=1, alu_src_a=1, alu_src_b=01, alu_op_type=00, alu_out_write=1, so ALUOut<=PC+imm.
  - imm_src is B for opcode 1100011, J for 1101111, U for 0010111, otherwise I.
  - Next state by opcode:
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 0000011 or 0100011 -> MEM_ADDR
    - 1100011 with funct3 000/001 -> BRANCH
    - 1101111 -> JUMP
    - 1100111 -> EXEC_JALR
    - 0010111 -> ALU_WB
    - anything else -> TRAP
- EXEC_R: alu_op_type=10, src_b=00, alu_out_write -> ALU_WB.
- EXEC_I: alu_op_type=11, src_b=01, imm I, alu_out_write -> ALU_WB.
- MEM_ADDR: src_b=01, imm I (load) or S (store), add, alu_out_write. Next: MEM_READ for a load, MEM_WRITE for a store.
- MEM_READ:
  - mem_read=1 for 1+DMEM_WAIT_CYCLES cycles, then MEM_WB.
  - The MDR latches on every cycle with mem_read=1; the final value is the one used.
- MEM_WRITE: mem_write=1, plus PC increment -> FETCH.
- MEM_WB: reg_write=1, mem_to_reg=1, plus PC increment -> FETCH.
- ALU_WB: reg_write=1, mem_to_reg=0, plus PC increment -> FETCH.
- PC increment: alu_src_a=1, alu_src_b=10, alu_op_type=00, pc_source=00, pc_write=1.
- BRANCH:
  - src_a=0, src_b=00, alu_op_type=01.
  - Taken when alu_zero_flag_in XOR funct3[0] is 1: pc_write=1, pc_source=01 -> FETCH.
  - Not taken -> PC_INC (PC increment only) -> FETCH.
- EXEC_JALR: src_a=0, src_b=01, imm I, add, alu_out_write -> JUMP. Bit 0 of the target is not cleared.
- JUMP:
  - pc_write=1, pc_source=01 (JAL) or 10 (JALR), so PC<=ALUOut target.
  - Same cycle: src_a=1, src_b=10, add, alu_out_write, so ALUOut<=old PC+4.
  - Next: JUMP_WB.
- JUMP_WB: reg_write=1, mem_to_reg=0 -> FETCH.
- TRAP: all enables 0, illegal_instr=1. Held until reset.
- Latency at zero wait cycles:
  - AUIPC, branch taken: 3 cycles
  - R, I, SW, branch not-taken, JAL: 4 cycles
  - LW, JALR: 5 cycles
- Reset asserted mid-instruction: the instruction is abandoned with no partial register or memory write in the reset cycle, and execution restarts at FETCH.

Optional Feature:
- Macro SIGMA_CTRL_INSTRET_EN.
- Defined: instret_count increments by 1 on every transition into FETCH from a completing state (not from reset or TRAP). It wraps at 2^32.
- Undefined: instret_count is tied to 0 and no counter flops are built.

Test Plan:
- Reset held 3 cycles, then released with ADD x3,x1,x2 (0x002081B3) -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 only in ALU_WB with mem_to_reg=0; pc_write=1 only in ALU_WB with pc_source=00.
- LW x5,8(x1) (0x0080A283) with DMEM_WAIT_CYCLES=2 -> mem_read high exactly 3 consecutive cycles, then MEM_WB with reg_write=1 and mem_to_reg=1; 7 cycles total.
- BEQ x1,x2,+16 (0x00208863): zero=1 -> pc_write with pc_source=01 in BRANCH; zero=0 -> PC_INC with pc_source=00. BNE (0x00209863) gives the inverse outcome.
- JAL x1,+32 (0x020000EF) -> DECODE imm_src=100; JUMP has pc_write=1, pc_source=01, alu_out_write=1; JUMP_WB has reg_write=1.
- Instruction 0x00000000 -> TRAP, illegal_instr=1, all enables 0 for 20 cycles; reset_n=0 for one edge clears it to FETCH.
- With SIGMA_CTRL_INSTRET_EN: 10 back-to-back ADDs -> instret_count=10. Without the macro -> instret_count=0 throughout.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// SigmaCore multicycle control bundle: IR/zero in, datapath controls out.
// master = control FSM side, slave = datapath side.
interface multicycle_control_fsm_if;
   logic [31:0] instruction_in;
   logic        alu_zero_flag_in;
   logic        pc_write;
   logic        ir_write;
   logic        reg_write;
   logic        mem_write;
   logic        mem_read;
   logic        reg_a_write;
   logic        reg_b_write;
   logic        alu_out_write;
   logic [1:0]  pc_source;
   logic        mem_to_reg;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  imm_src;
   logic [1:0]  alu_op_type;
   logic        illegal_instr;
   logic [3:0]  state_out;
   logic [31:0] instret_count;

   modport master (
      input  instruction_in, alu_zero_flag_in,
      output pc_write, ir_write, reg_write,
      output mem_write, mem_read,
      output reg_a_write, reg_b_write,
      output alu_out_write, pc_source,
      output mem_to_reg, alu_src_a, alu_src_b,
      output imm_src, alu_op_type,
      output illegal_instr, state_out,
      output instret_count
   );

   modport slave (
      output instruction_in, alu_zero_flag_in,
      input  pc_write, ir_write, reg_write,
      input  mem_write, mem_read,
      input  reg_a_write, reg_b_write,
      input  alu_out_write, pc_source,
      input  mem_to_reg, alu_src_a, alu_src_b,
      input  imm_src, alu_op_type,
      input  illegal_instr, state_out,
      input  instret_count
   );
endinterface

// File: rtl/multicycle_control_fsm.sv
// SigmaCore multicycle Moore control FSM (RV32I subset, sticky trap).
// Optional retired-instruction counter: define SIGMA_CTRL_INSTRET_EN.
module multicycle_control_fsm #(
   parameter int IMEM_WAIT_CYCLES = 0,
   parameter int DMEM_WAIT_CYCLES = 0
) (
   input logic clk,
   input logic reset_n,
   multicycle_control_fsm_if.master ctrl
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_EXEC_R    = 4'd2,
      S_EXEC_I    = 4'd3,
      S_MEM_ADDR  = 4'd4,
      S_MEM_READ  = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_MEM_WB    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_PC_INC    = 4'd10,
      S_EXEC_JALR = 4'd11,
      S_JUMP      = 4'd12,
      S_JUMP_WB   = 4'd13,
      S_TRAP      = 4'd14
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   state_t      state;
   state_t      nxt;
   logic [15:0] wait_cnt;
   logic        illegal;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        last_fetch;
   logic        last_read;
   logic        unused_bits;

   assign opcode      = ctrl.instruction_in[6:0];
   assign funct3      = ctrl.instruction_in[14:12];
   assign unused_bits = ^{ctrl.instruction_in[31:15],
                          ctrl.instruction_in[11:7]};
   assign last_fetch  = (wait_cnt == 16'(IMEM_WAIT_CYCLES));
   assign last_read   = (wait_cnt == 16'(DMEM_WAIT_CYCLES));

   // One shared wait counter; it restarts on every state change.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         illegal  <= 1'b0;
      end else begin
         state <= nxt;
         if (nxt != state)
            wait_cnt <= '0;
         else if (state == S_FETCH || state == S_MEM_READ)
            wait_cnt <= wait_cnt + 16'd1;
         if (nxt == S_TRAP)
            illegal <= 1'b1;
      end
   end

   always_comb begin
      nxt                = state;
      ctrl.pc_write      = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.mem_read      = 1'b0;
      ctrl.reg_a_write   = 1'b0;
      ctrl.reg_b_write   = 1'b0;
      ctrl.alu_out_write = 1'b0;
      ctrl.pc_source     = 2'b00;
      ctrl.mem_to_reg    = 1'b0;
      ctrl.alu_src_a     = 1'b0;
      ctrl.alu_src_b     = 2'b00;
      ctrl.imm_src       = 3'b000;
      ctrl.alu_op_type   = 2'b00;
      unique case (state)
         S_FETCH: begin
            if (last_fetch) begin
               ctrl.ir_write = 1'b1;
               nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            ctrl.reg_a_write   = 1'b1;
            ctrl.reg_b_write   = 1'b1;
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = 2'b01;
            ctrl.alu_out_write = 1'b1;
            case (opcode)
               OP_BR:    ctrl.imm_src = 3'b010;
               OP_JAL:   ctrl.imm_src = 3'b100;
               OP_AUIPC: ctrl.imm_src = 3'b011;
               default:  ctrl.imm_src = 3'b000;
            endcase
            case (opcode)
               OP_R:     nxt = S_EXEC_R;
               OP_I:     nxt = S_EXEC_I;
               OP_LOAD,
               OP_STORE: nxt = S_MEM_ADDR;
               OP_BR:    nxt = (funct3[2:1] == 2'b00) ?
                               S_BRANCH : S_TRAP;
               OP_JAL:   nxt = S_JUMP;
               OP_JALR:  nxt = S_EXEC_JALR;
               OP_AUIPC: nxt = S_ALU_WB;
               default:  nxt = S_TRAP;
            endcase
         end
         S_EXEC_R: begin
            ctrl.alu_op_type   = 2'b10;
            ctrl.alu_out_write = 1'b1;
            nxt = S_ALU_WB;
         end
         S_EXEC_I: begin
            ctrl.alu_op_type   = 2'b11;
            ctrl.alu_src_b     = 2'b01;
            ctrl.alu_out_write = 1'b1;
            nxt = S_ALU_WB;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_b     = 2'b01;
            ctrl.alu_out_write = 1'b1;
            if (opcode == OP_STORE) begin
               ctrl.imm_src = 3'b001;
               nxt = S_MEM_WRITE;
            end else begin
               nxt = S_MEM_READ;
            end
         end
         S_MEM_READ: begin
            ctrl.mem_read = 1'b1;
            if (last_read)
               nxt = S_MEM_WB;
         end
         S_MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.pc_write  = 1'b1;
            nxt = S_FETCH;
         end
         S_MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = 2'b10;
            ctrl.pc_write   = 1'b1;
            nxt = S_FETCH;
         end
         S_ALU_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.pc_write  = 1'b1;
            nxt = S_FETCH;
         end
         S_BRANCH: begin
            ctrl.alu_op_type = 2'b01;
            // BNE (funct3[0]=1) inverts the sense of the zero flag
            if (ctrl.alu_zero_flag_in ^ funct3[0]) begin
               ctrl.pc_write  = 1'b1;
               ctrl.pc_source = 2'b01;
               nxt = S_FETCH;
            end else begin
               nxt = S_PC_INC;
            end
         end
         S_PC_INC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.pc_write  = 1'b1;
            nxt = S_FETCH;
         end
         S_EXEC_JALR: begin
            ctrl.alu_src_b     = 2'b01;
            ctrl.alu_out_write = 1'b1;
            nxt = S_JUMP;
         end
         S_JUMP: begin
            ctrl.pc_write      = 1'b1;
            ctrl.pc_source     = (opcode == OP_JAL) ?
                                 2'b01 : 2'b10;
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = 2'b10;
            ctrl.alu_out_write = 1'b1;
            nxt = S_JUMP_WB;
         end
         S_JUMP_WB: begin
            ctrl.reg_write = 1'b1;
            nxt = S_FETCH;
         end
         S_TRAP: nxt = S_TRAP;
         default: nxt = S_FETCH;
      endcase
      // Reset cycle must never leave a partial write behind
      if (!reset_n) begin
         ctrl.pc_write      = 1'b0;
         ctrl.ir_write      = 1'b0;
         ctrl.reg_write     = 1'b0;
         ctrl.mem_write     = 1'b0;
         ctrl.mem_read      = 1'b0;
         ctrl.reg_a_write   = 1'b0;
         ctrl.reg_b_write   = 1'b0;
         ctrl.alu_out_write = 1'b0;
      end
   end

   assign ctrl.illegal_instr = illegal;
   assign ctrl.state_out     = state;

`ifdef SIGMA_CTRL_INSTRET_EN
   logic [31:0] instret;

   always_ff @(posedge clk) begin
      if (!reset_n)
         instret <= '0;
      else if (nxt == S_FETCH && state != S_FETCH &&
               state != S_TRAP)
         instret <= instret + 32'd1;
   end

   assign ctrl.instret_count = instret;
`else
   assign ctrl.instret_count = '0;
`endif

endmodule
